// File: rtl/ballot_console.sv
// ballot_console -- voter-booth front end feeding one ballot at a time into
// the vote tally unit.
//
// An officer arms the booth with a rising Enable. The voter picks a candidate
// with Key and confirms. The console then issues a one-cycle Ballot strobe
// with IN carrying the candidate for HOLD_CYC cycles, pulses Sent, counts the
// ballot and relocks.
//
// Ports
//   clk      in   1   system clock, rising edge
//   Power    in   1   synchronous active-high reset
//   Enable   in   1   officer arm request, level-sampled (arms on rising level)
//   Close    in   1   polls closed
//   Key      in   4   voter key code, 0 = no key
//   Confirm  in   1   voter confirm
//   Cancel   in   1   voter cancel
//   Ballot   out  1   one-cycle strobe to tally
//   IN       out  4   candidate code to tally, 0 when idle
//   Sel      out  4   currently selected candidate (display)
//   Ready    out  1   booth armed lamp (ARMED or SELECT)
//   Sent     out  1   one-cycle pulse when a transmission completes
//   Timeout  out  1   sticky idle-abort flag
//   issued   out  12  ballots transmitted, modulo 4096
module ballot_console #(
  parameter int MAX_CAND = 15,
  parameter int HOLD_CYC = 4,
  parameter int TIMEOUT  = 1000
) (
  input  logic        clk,
  input  logic        Power,
  input  logic        Enable,
  input  logic        Close,
  input  logic [3:0]  Key,
  input  logic        Confirm,
  input  logic        Cancel,
  output logic        Ballot,
  output logic [3:0]  IN,
  output logic [3:0]  Sel,
  output logic        Ready,
  output logic        Sent,
  output logic        Timeout,
  output logic [11:0] issued
);

  localparam int HW = $clog2(HOLD_CYC + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYC);
  localparam logic [15:0]   TMO_LAST  = 16'(TIMEOUT - 1);

  typedef enum logic [2:0] {LOCKED, ARMED, SELECT, SEND, DONE} state_t;

  state_t        state_q, state_d;
  logic [3:0]    sel_q, sel_d;
  logic [3:0]    in_q, in_d;
  logic          ballot_q, ballot_d;
  logic          ready_q, ready_d;
  logic          sent_q, sent_d;
  logic          timeout_q, timeout_d;
  logic [11:0]   issued_q, issued_d;
  logic [15:0]   timer_q, timer_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          en_prev_q, en_prev_d;

  logic key_valid;
  logic arm_req;

  assign key_valid = (Key != 4'd0) && (int'(Key) <= MAX_CAND);
  // Arming needs a fresh rising level, so a held Enable cannot re-arm after DONE.
  assign arm_req   = Enable && !en_prev_q;

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    in_d      = in_q;
    ballot_d  = 1'b0;
    sent_d    = 1'b0;
    timeout_d = timeout_q;
    issued_d  = issued_q;
    timer_d   = timer_q;
    hold_d    = hold_q;
    en_prev_d = Enable;

    case (state_q)
      LOCKED: begin
        if (arm_req && !Close) begin
          state_d   = ARMED;
          timeout_d = 1'b0;
          timer_d   = 16'd0;
        end
      end
      ARMED: begin
        // Confirm and Cancel have no effect until a candidate is chosen.
        if (Close) begin
          state_d = LOCKED;
          sel_d   = 4'd0;
        end else if (timer_q == TMO_LAST) begin
          state_d   = LOCKED;
          sel_d     = 4'd0;
          timeout_d = 1'b1;
        end else if (key_valid) begin
          state_d = SELECT;
          sel_d   = Key;
          timer_d = 16'd0;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      SELECT: begin
        // Cancel beats Confirm; a Key presented with Confirm is dropped.
        if (Close) begin
          state_d = LOCKED;
          sel_d   = 4'd0;
        end else if (timer_q == TMO_LAST) begin
          state_d   = LOCKED;
          sel_d     = 4'd0;
          timeout_d = 1'b1;
        end else if (Cancel) begin
          state_d = ARMED;
          sel_d   = 4'd0;
          timer_d = 16'd0;
        end else if (Confirm) begin
          state_d  = SEND;
          ballot_d = 1'b1;
          in_d     = sel_q;
          hold_d   = HW'(1);
        end else if (key_valid) begin
          sel_d   = Key;
          timer_d = 16'd0;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      SEND: begin
        // hold_q counts cycles IN has already been driven, Ballot cycle included.
        if (hold_q == HOLD_LAST) begin
          state_d  = DONE;
          in_d     = 4'd0;
          sent_d   = 1'b1;
          issued_d = issued_q + 12'd1;
          sel_d    = 4'd0;
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      DONE: begin
        state_d = LOCKED;
      end
      default: begin
        state_d = LOCKED;
      end
    endcase

    ready_d = (state_d == ARMED) || (state_d == SELECT);
  end

  always_ff @(posedge clk) begin
    if (Power) begin
      state_q   <= LOCKED;
      sel_q     <= 4'd0;
      in_q      <= 4'd0;
      ballot_q  <= 1'b0;
      ready_q   <= 1'b0;
      sent_q    <= 1'b0;
      timeout_q <= 1'b0;
      issued_q  <= 12'd0;
      timer_q   <= 16'd0;
      hold_q    <= '0;
      en_prev_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      in_q      <= in_d;
      ballot_q  <= ballot_d;
      ready_q   <= ready_d;
      sent_q    <= sent_d;
      timeout_q <= timeout_d;
      issued_q  <= issued_d;
      timer_q   <= timer_d;
      hold_q    <= hold_d;
      en_prev_q <= en_prev_d;
    end
  end

  assign Ballot  = ballot_q;
  assign IN      = in_q;
  assign Sel     = sel_q;
  assign Ready   = ready_q;
  assign Sent    = sent_q;
  assign Timeout = timeout_q;
  assign issued  = issued_q;

endmodule
